seq_detect_sched: RTL and testbench
===================================

Name: seq_detect_sched

Overview:
- Round-robin scheduler that shares one serial run-of-ones detector among N_REQ requesters.
- Each requester hands over a FRAME_LEN-bit frame using a valid/ready handshake.
- The block shifts the granted frame LSB-first into the detector, counts detector hits, and returns a tagged hit count.
- Sits between the frame producers and the single detection resource, so the detector is never driven by two sources at once.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_LEN, 8, bits per frame (>= PAT_W).
- PAT_W, 4, consecutive 1s that constitute one detector hit.
- ID_W, $clog2(N_REQ), width of the requester index.
- HIT_W, $clog2(FRAME_LEN+1), width of the hit counter.

Ports:
- clk, input, 1, single rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- req_valid, input, N_REQ, per-requester frame valid. Must be held until req_ready.
- req_data, input, N_REQ*FRAME_LEN, frame of requester i is in slice [i*FRAME_LEN +: FRAME_LEN].
- req_ready, output, N_REQ, one-hot one-cycle grant/capture strobe.
- done_valid, output, 1, one-cycle result strobe.
- done_id, output, ID_W, requester whose frame produced the result.
- done_hits, output, HIT_W, number of detector hits in that frame.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Clock and reset: one clock `clk`. `reset_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE, req_ready=0, done_valid=0, done_id=0, done_hits=0, busy=0.
  - RR pointer=N_REQ-1, so requester 0 wins first.
  - Detector cleared.
  - Reset asserted mid-frame aborts the frame; no done_valid is issued for it.
- FSM states: IDLE, GRANT, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req_valid is high at the edge, latch the winner and go to GRANT; otherwise stay.
  - Winner = first valid index strictly after the RR pointer, wrapping modulo N_REQ.
- GRANT (1 cycle):
  - req_ready[winner]=1. Capture req_data slice into the shift register.
  - Update RR pointer to winner. Clear the detector and the hit counter.
  - Go to SHIFT.
- SHIFT (FRAME_LEN cycles):
  - Each cycle, present shift-register bit 0 to the detector and shift right.
  - Bit counter runs 0..FRAME_LEN-1; go to DRAIN after the last bit.
- DRAIN (1 cycle): absorbs the registered detector output for the final bit.
- Hit counting: hit counter increments in every SHIFT and DRAIN cycle in which detector match=1. It never wraps; the maximum count is FRAME_LEN/PAT_W.
- DONE (1 cycle):
  - done_valid=1; done_id and done_hits are registered and stable this cycle.
  - If any req_valid is high, arbitrate as in IDLE and go to GRANT (back-to-back frames, no IDLE bubble); otherwise go to IDLE.
- Latency: req_valid sampled in IDLE at cycle 0 -> req_ready at cycle 1 -> done_valid at cycle FRAME_LEN+3 (cycle 11 for defaults).
- Steady-state throughput: one frame per FRAME_LEN+3 cycles.
- Detector (Moore, registered):
  - Run counter c in 0..PAT_W. match = (c==PAT_W).
  - din=0 -> c=0.
  - din=1 -> c = (c==PAT_W) ? 1 : c+1. After a match, a 1 starts a new run (non-overlapping).
  - Detector is cleared in GRANT, so no run carries across frames.
- Handshake rules:
  - req_valid deasserted before grant simply removes that requester from arbitration.
  - Requesters other than the winner keep their valid held; nothing is dropped.
- Ports: req_ready and done_valid are never high in the same cycle.

Decomposition:
- Package seq_sched_pkg:
  - typedef enum logic [2:0] sched_state_t {IDLE, GRANT, SHIFT, DRAIN, DONE}.
  - Function rr_pick(valid, ptr) returning the winner index.
- Sub-module run_detect:
  - Params PAT_W.
  - Ports clk, reset_n, clr, din, match.
  - Registered Moore run detector as specified above.

Test Plan:
- Single requester 0, req_data=8'hFF -> req_ready[0] at cycle 1, done_valid at cycle 11, done_id=0, done_hits=2.
- Requester 2, frame 8'b0111_1011 (LSB-first bits 1,1,0,1,1,1,1,0) -> done_id=2, done_hits=1. Frame 8'h00 -> done_hits=0.
- All four valid, continuously re-asserted:
  - Grant order is 0,1,2,3,0.
  - DONE goes straight to GRANT with no IDLE cycle.
  - busy stays 1 throughout.
- Two consecutive 8'hF0 frames from requester 1 -> done_hits=1 each. Two consecutive 8'hFF frames -> done_hits=2 each, proving the detector clears between frames.
- reset_n pulsed low during SHIFT bit 4:
  - All outputs are 0 immediately (asynchronous).
  - No done_valid is issued for the aborted frame.
  - The next grant goes to requester 0.
- Requester 3 drops req_valid while requester 1 is being shifted -> requester 3 is never granted and no stray req_ready appears. Pointer=1 with valids {0,2} -> requester 2 wins.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared types and the round-robin pick function for the run-of-ones
// detector scheduler.
package seq_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // Widest requester count the pick function handles.
  localparam int unsigned MAX_REQ = 8;

  // First valid index strictly after ptr, wrapping modulo n.
  // Returns 0 when nothing is valid; callers only use it when |valid.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0] win;
    logic       found;
    logic [2:0] idx;
    win   = 3'd0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      if (i <= n) begin
        idx = 3'((32'(ptr) + i) % n);
        if (!found && valid[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/run_detect.sv
// Registered Moore detector for runs of PAT_W consecutive ones.
// Runs do not overlap: a 1 after a match starts a fresh run.
module run_detect #(
  parameter int unsigned PAT_W = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic din,
  output logic match
);

  localparam int unsigned CW = $clog2(PAT_W + 1);

  logic [CW-1:0] run_cnt;

  // Run counter: cleared on clr or a 0, restarts at 1 after a full run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
    end else if (clr || !din) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(PAT_W)) begin
      run_cnt <= CW'(1);
    end else begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

  assign match = (run_cnt == CW'(PAT_W));

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one run-of-ones detector among N_REQ
// requesters. A granted frame is shifted LSB-first through the detector and
// the hit count comes back tagged with the requester index.
//
// Handshake: a requester raises req_valid[i] with its frame on its req_data
// slice and holds both until it sees req_ready[i]. req_ready[i] is a
// one-cycle strobe during which the frame is captured; the requester may
// drop or refresh valid/data after that cycle. Dropping valid before the
// grant simply withdraws the request. done_valid is a one-cycle strobe with
// done_id/done_hits stable in that cycle; there is no backpressure on it.
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned PAT_W     = 4,
  parameter int unsigned ID_W      = $clog2(N_REQ),
  parameter int unsigned HIT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*FRAME_LEN-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       done_valid,
  output logic [ID_W-1:0]            done_id,
  output logic [HIT_W-1:0]           done_hits,
  output logic                       busy,
  output sched_state_t               dbg_state
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  sched_state_t           state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        pick;
  logic [FRAME_LEN-1:0]   shreg;
  logic [FRAME_LEN-1:0]   win_data;
  logic [CNT_W-1:0]       bit_cnt;
  logic [HIT_W-1:0]       hit_cnt;
  logic                   det_clr;
  logic                   det_din;
  logic                   det_match;

  assign pick = ID_W'(rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), N_REQ));

  // Select the latched winner's frame slice for capture in GRANT.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (winner == ID_W'(i)) begin
        win_data = req_data[i*FRAME_LEN +: FRAME_LEN];
      end
    end
  end

  // Only SHIFT feeds real bits; every other state presents 0 so the run
  // counter never sees stale data.
  assign det_clr = (state == GRANT);
  assign det_din = (state == SHIFT) && shreg[0];

  run_detect #(
    .PAT_W (PAT_W)
  ) u_run_detect (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (det_clr),
    .din     (det_din),
    .match   (det_match)
  );

  // Scheduler FSM with registered strobes and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(N_REQ - 1);
      winner     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      hit_cnt    <= '0;
      req_ready  <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_hits  <= '0;
      busy       <= 1'b0;
    end else begin
      req_ready  <= '0;
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            winner    <= pick;
            req_ready <= N_REQ'(1) << pick;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          shreg   <= win_data;
          rr_ptr  <= winner;
          hit_cnt <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          shreg <= {1'b0, shreg[FRAME_LEN-1:1]};
          if (det_match) hit_cnt <= hit_cnt + HIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state <= DRAIN;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          // The last bit's match only becomes visible in this cycle.
          hit_cnt    <= hit_cnt + HIT_W'(det_match);
          done_hits  <= hit_cnt + HIT_W'(det_match);
          done_id    <= winner;
          done_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (|req_valid) begin
            winner    <= pick;
            req_ready <= N_REQ'(1) << pick;
            state     <= GRANT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: reset values, latency, hit counting,
// round-robin order, back-to-back frames, mid-frame reset and withdrawn
// requests.
module tb_seq_detect_sched;
  import seq_sched_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [31:0]  req_data = '0;
  logic [3:0]   req_ready;
  logic         done_valid;
  logic [1:0]   done_id;
  logic [3:0]   done_hits;
  logic         busy;
  sched_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  seq_detect_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_hits  (done_hits),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset_n   = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  // Drive one frame from an idle DUT; report the grant seen in cycle 1 and
  // the cycle (counted from the request cycle 0) of done_valid, or -1.
  task automatic send_frame(input int id, input logic [7:0] frame,
                            output logic [3:0] rdy1, output int dcyc,
                            output logic [1:0] did, output logic [3:0] dhits);
    req_data[id*8 +: 8] = frame;
    req_valid[id] = 1'b1;
    step();
    rdy1 = req_ready;
    req_valid[id] = 1'b0;
    dcyc  = -1;
    did   = '0;
    dhits = '0;
    for (int c = 2; c <= 30; c++) begin
      step();
      if (done_valid) begin
        dcyc  = c;
        did   = done_id;
        dhits = done_hits;
        break;
      end
    end
  endtask

  // Bounded wait for busy to drop; ok=0 when the bound expires.
  task automatic wait_idle(output int ok);
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step();
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    n_cmp++; if (done_id !== 2'd0) begin n_err++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
    n_cmp++; if (done_hits !== 4'd0) begin n_err++; $display("FAIL reset_done_hits: got %0d want 0", done_hits); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [3:0] r; int c; logic [1:0] id; logic [3:0] h;
    do_reset();
    send_frame(0, 8'hFF, r, c, id, h);
    n_cmp++; if (r !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", r); end
    n_cmp++; if (c != 11) begin n_err++; $display("FAIL single_latency: got %0d want 11", c); end
    n_cmp++; if (id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", id); end
    n_cmp++; if (h !== 4'd2) begin n_err++; $display("FAIL single_hits: got %0d want 2", h); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL single_ready_in_done: got %b want 0000", req_ready); end
    step();
    n_cmp++; if (busy !== 1'b0 || done_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: busy=%b done_valid=%b want 0 0", busy, done_valid); end
  endtask

  task automatic test_pattern();
    logic [3:0] r; int c; logic [1:0] id; logic [3:0] h;
    send_frame(2, 8'b0111_1011, r, c, id, h);
    n_cmp++; if (r !== 4'b0100) begin n_err++; $display("FAIL pat_ready: got %b want 0100", r); end
    n_cmp++; if (c != 11) begin n_err++; $display("FAIL pat_latency: got %0d want 11", c); end
    n_cmp++; if (id !== 2'd2) begin n_err++; $display("FAIL pat_id: got %0d want 2", id); end
    n_cmp++; if (h !== 4'd1) begin n_err++; $display("FAIL pat_hits_7b: got %0d want 1", h); end
    step();
    send_frame(2, 8'h00, r, c, id, h);
    n_cmp++; if (h !== 4'd0 || id !== 2'd2) begin n_err++; $display("FAIL pat_hits_00: got id=%0d hits=%0d want id=2 hits=0", id, h); end
    step();
  endtask

  task automatic test_back_to_back();
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int ng = 0; int busy_bad = 0; int adj = 0; int not_onehot = 0; int ok;
    logic prev_done = 1'b0;
    do_reset();
    req_data  = 32'h0F_3C_F0_FF;
    req_valid = 4'hF;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (busy !== 1'b1) busy_bad++;
      if (req_ready !== 4'b0) begin
        if (!$onehot(req_ready)) not_onehot++;
        order[ng] = 0;
        for (int k = 0; k < 4; k++) if (req_ready[k]) order[ng] = k;
        if (prev_done) adj++;
        ng++;
        if (ng == 5) break;
      end
      prev_done = done_valid;
    end
    req_valid = '0;
    n_cmp++; if (ng != 5) begin n_err++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (k < ng && order[k] != exp_order[k]) begin n_err++; $display("FAIL rr_order_%0d: got %0d want %0d", k, order[k], exp_order[k]); end
    end
    n_cmp++; if (busy_bad != 0) begin n_err++; $display("FAIL rr_busy: got %0d low cycles want 0", busy_bad); end
    n_cmp++; if (adj != 4) begin n_err++; $display("FAIL rr_no_bubble: got %0d done->grant adjacencies want 4", adj); end
    n_cmp++; if (not_onehot != 0) begin n_err++; $display("FAIL rr_onehot: got %0d non-onehot grants want 0", not_onehot); end
    wait_idle(ok);
    n_cmp++; if (ok != 1) begin n_err++; $display("FAIL rr_drain: got busy stuck want idle"); end
  endtask

  task automatic test_detector_clear();
    logic [3:0] r; int c; logic [1:0] id; logic [3:0] h;
    logic [7:0] frames[4] = '{8'hF0, 8'hF0, 8'hFF, 8'hFF};
    int exp_hits[4] = '{1, 1, 2, 2};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_frame(1, frames[k], r, c, id, h);
      n_cmp++; if (id !== 2'd1 || h !== 4'(exp_hits[k])) begin n_err++; $display("FAIL clear_frame_%0d: got id=%0d hits=%0d want id=1 hits=%0d", k, id, h, exp_hits[k]); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] r; int c; logic [1:0] id; logic [3:0] h; int stray_done = 0; int ok;
    do_reset();
    send_frame(1, 8'hFF, r, c, id, h);
    n_cmp++; if (id !== 2'd1 || h !== 4'd2) begin n_err++; $display("FAIL rmid_pre: got id=%0d hits=%0d want id=1 hits=2", id, h); end
    step();
    req_data[15:8] = 8'hFF;
    req_valid[1] = 1'b1;
    step();
    req_valid = '0;
    repeat (5) step();
    n_cmp++; if (dbg_state !== SHIFT) begin n_err++; $display("FAIL rmid_in_shift: got %0d want SHIFT", dbg_state); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0 || done_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_async_ctl: got ready=%b dv=%b busy=%b want 0", req_ready, done_valid, busy); end
    n_cmp++; if (done_id !== 2'd0 || done_hits !== 4'd0) begin n_err++; $display("FAIL rmid_async_result: got id=%0d hits=%0d want 0 0", done_id, done_hits); end
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done_valid) stray_done++;
    end
    n_cmp++; if (stray_done != 0) begin n_err++; $display("FAIL rmid_no_done: got %0d strobes want 0", stray_done); end
    req_valid = 4'b0101;
    step();
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_next_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    wait_idle(ok);
    n_cmp++; if (ok != 1) begin n_err++; $display("FAIL rmid_drain: got busy stuck want idle"); end
  endtask

  task automatic test_withdraw();
    int stray = 0; int dcnt = 0; int ok;
    logic [1:0] id = '0; logic [3:0] h = '0;
    do_reset();
    req_data[15:8] = 8'h3C;
    req_valid = 4'b1010;
    step();
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wd_grant1: got %b want 0010", req_ready); end
    req_valid[1] = 1'b0;
    repeat (3) step();
    req_valid[3] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (req_ready !== 4'b0) stray++;
      if (done_valid) begin
        dcnt++;
        id = done_id;
        h  = done_hits;
      end
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL wd_stray_ready: got %0d want 0", stray); end
    n_cmp++; if (dcnt != 1 || id !== 2'd1 || h !== 4'd1) begin n_err++; $display("FAIL wd_result: got n=%0d id=%0d hits=%0d want n=1 id=1 hits=1", dcnt, id, h); end
    req_valid = 4'b0101;
    step();
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wd_ptr1_pick: got %b want 0100", req_ready); end
    req_valid = '0;
    wait_idle(ok);
    n_cmp++; if (ok != 1) begin n_err++; $display("FAIL wd_drain: got busy stuck want idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pattern();
    test_back_to_back();
    test_detector_clear();
    test_reset_mid();
    test_withdraw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
